// File: rtl/bus_hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_hs_pkg
//  Purpose  : Shared definitions for the handshake source/destination family:
//             counter width, constant-safe log2 and power-of-two helpers, and
//             the handshake-fire function.
//  Revision : 1.0 - initial release
// ============================================================================
package bus_hs_pkg;

   localparam int CNT_W = 32;

   // Ceiling log2, usable in parameter and port-width expressions.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >>> 1;
      end
      return result;
   endfunction

   // True when value is a power of two that is at least 2.
   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

   // A transfer happens on a clock edge where both sides agree.
   function automatic logic hs_fire(input logic valid, input logic ready);
      return valid & ready;
   endfunction

endpackage : bus_hs_pkg
`default_nettype wire

// File: rtl/destination_v2_if.sv
`default_nettype none
// ============================================================================
//  Module   : destination_v2_if
//  Purpose  : Upstream valid/ready handshake plus downstream idle/drain bus
//             of the destination sink.
//  Revision : 1.0 - initial release
// ============================================================================
interface destination_v2_if #(
   parameter int WIDTH = 9
);
   logic             vaild;
   logic [WIDTH-1:0] data_in;
   logic             ready;
   logic             idle;
   logic             out_vaild;
   logic [WIDTH-1:0] data_out;

   // Environment side: produces words and consumer idle, observes drain.
   modport master (
      output vaild, data_in, idle,
      input  ready, out_vaild, data_out
   );

   // Sink side.
   modport slave (
      input  vaild, data_in, idle,
      output ready, out_vaild, data_out
   );
endinterface : destination_v2_if
`default_nettype wire

// File: rtl/destination_v2_sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_mem
//  Purpose  : DEPTH x WIDTH storage with one write port and one registered
//             read port. The array itself is not reset; only the read
//             register is.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_wr_en,
   input  wire logic [AW-1:0]    i_wr_addr,
   input  wire logic [WIDTH-1:0] i_wr_data,
   input  wire logic             i_rd_en,
   input  wire logic [AW-1:0]    i_rd_addr,
   output logic      [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] rd_data_d;

   // Storage write; no reset so the array can map onto RAM.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

   // Read register loads only on a read and otherwise holds the last word.
   always_comb begin
      rd_data_d = rd_data_q;
      if (i_rd_en) begin
         rd_data_d = mem_q[i_rd_addr];
      end
   end

   // Read register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign o_rd_data = rd_data_q;

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/destination_v2.sv
`default_nettype none
// ============================================================================
//  Module   : destination_v2
//  Purpose  : Handshake sink with a DEPTH-entry FIFO drained one word per
//             cycle while the consumer is idle. Reports fill level,
//             almost-full, a saturating accepted-word counter and an
//             optional sticky sequence checker for incrementing streams.
//  Revision : 1.0 - initial release
// ============================================================================
module destination_v2
   import bus_hs_pkg::*;
#(
   parameter int WIDTH     = 9,
   parameter int DEPTH     = 256,
   parameter int AF_LEVEL  = 192,
   parameter int CHECK_SEQ = 1
) (
   input  wire logic              clk,
   input  wire logic              s_rst,
   destination_v2_if.slave        bus,
   output logic [clog2(DEPTH):0]  fill_level,
   output logic                   almost_full,
   output logic [CNT_W-1:0]       rx_cnt,
   output logic                   seq_err
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);

   // Elaboration-time parameter sanity.
   if (!is_pow2(DEPTH)) begin : g_depth_err
      $error("destination_v2: DEPTH must be a power of two >= 2");
   end
   if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_af_err
      $error("destination_v2: AF_LEVEL must lie in 1..DEPTH");
   end
   if (WIDTH < 1) begin : g_width_err
      $error("destination_v2: WIDTH must be >= 1");
   end

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    fill_q, fill_d;
   logic             almost_full_q, almost_full_d;
   logic             out_vaild_q, out_vaild_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic             ready;
   logic             wr_en;
   logic             rd_en;

   // Ready depends only on reset and the registered fill level, never on
   // vaild or idle, so upstream sees no combinational loop through us.
   assign ready = !s_rst && (fill_q != FULL_LVL);
   assign wr_en = hs_fire(bus.vaild, ready);
   assign rd_en = bus.idle && (fill_q != '0);

   // Next-state for pointers, fill level, flags and the accept counter.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fill_d        = fill_q;
      rx_cnt_d      = rx_cnt_q;
      out_vaild_d   = rd_en;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (rx_cnt_q != '1) begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
         end
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      // Simultaneous write and read leaves the level unchanged.
      case ({wr_en, rd_en})
         2'b10:   fill_d = fill_q + LW'(1);
         2'b01:   fill_d = fill_q - LW'(1);
         default: fill_d = fill_q;
      endcase

      almost_full_d = (fill_d >= AF_LVL);
   end

   // Control register bank; reset discards everything stored.
   always_ff @(posedge clk) begin
      if (s_rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fill_q        <= '0;
         almost_full_q <= 1'b0;
         out_vaild_q   <= 1'b0;
         rx_cnt_q      <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fill_q        <= fill_d;
         almost_full_q <= almost_full_d;
         out_vaild_q   <= out_vaild_d;
         rx_cnt_q      <= rx_cnt_d;
      end
   end

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .rst       (s_rst),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_ptr_q),
      .i_wr_data (bus.data_in),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_ptr_q),
      .o_rd_data (bus.data_out)
   );

   if (CHECK_SEQ != 0) begin : g_seq
      logic             started_q, started_d;
      logic [WIDTH-1:0] expect_q, expect_d;
      logic             err_q, err_d;

      // Compare each accepted word with its predecessor + 1. The expected
      // value always reloads from the accepted word so a single glitch
      // flags once instead of cascading through the rest of the stream.
      always_comb begin
         started_d = started_q;
         expect_d  = expect_q;
         err_d     = err_q;
         if (wr_en) begin
            started_d = 1'b1;
            expect_d  = bus.data_in + WIDTH'(1);
            if (started_q && (bus.data_in != expect_q)) begin
               err_d = 1'b1;
            end
         end
      end

      // Checker state; the error flag is sticky until reset.
      always_ff @(posedge clk) begin
         if (s_rst) begin
            started_q <= 1'b0;
            expect_q  <= '0;
            err_q     <= 1'b0;
         end else begin
            started_q <= started_d;
            expect_q  <= expect_d;
            err_q     <= err_d;
         end
      end

      assign seq_err = err_q;
   end else begin : g_no_seq
      assign seq_err = 1'b0;
   end

   assign bus.ready     = ready;
   assign bus.out_vaild = out_vaild_q;
   assign fill_level    = fill_q;
   assign almost_full   = almost_full_q;
   assign rx_cnt        = rx_cnt_q;

endmodule : destination_v2
`default_nettype wire

// File: tb/tb_destination_v2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_destination_v2
//  Purpose  : Directed self-checking bench for destination_v2 with DEPTH=8,
//             AF_LEVEL=6, WIDTH=9.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_destination_v2;

   localparam int WIDTH    = 9;
   localparam int DEPTH    = 8;
   localparam int AF_LEVEL = 6;
   localparam int LIMIT    = 2000;

   logic        clk   = 1'b0;
   logic        s_rst = 1'b1;
   logic [3:0]  fill_level;
   logic        almost_full;
   logic [31:0] rx_cnt;
   logic        seq_err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int max_fill = 0;

   logic [WIDTH-1:0] out_q[$];
   int               stamp_q[$];

   destination_v2_if #(.WIDTH(WIDTH)) ifc ();

   destination_v2 #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_LEVEL  (AF_LEVEL),
      .CHECK_SEQ (1)
   ) dut (
      .clk         (clk),
      .s_rst       (s_rst),
      .bus         (ifc),
      .fill_level  (fill_level),
      .almost_full (almost_full),
      .rx_cnt      (rx_cnt),
      .seq_err     (seq_err)
   );

   always #5 clk = ~clk;

   // Output monitor on the falling edge: captures drained words in order.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (ifc.out_vaild === 1'b1) begin
         out_q.push_back(ifc.data_out);
         stamp_q.push_back(cyc);
      end
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one word and hold it until accepted (bounded).
   task automatic send(input logic [WIDTH-1:0] d);
      int t;
      t = 0;
      @(negedge clk);
      ifc.vaild   = 1'b1;
      ifc.data_in = d;
      while (ifc.ready !== 1'b1 && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      assert (t < LIMIT) else begin
         n_errors++;
         $error("FAIL send_timeout: observed no accept of %0h expected accept within %0d cycles", d, LIMIT);
         ifc.vaild = 1'b0;
         return;
      end
      @(posedge clk);
      #1 ifc.vaild = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_capture();
      out_q.delete();
      stamp_q.delete();
      max_fill = 0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      s_rst = 1'b1;
      @(negedge clk);
      s_rst = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] exp_w;
      logic [WIDTH-1:0] seq5 [6];
      seq5 = '{9'd5, 9'd6, 9'd7, 9'd9, 9'd10, 9'd11};

      ifc.vaild   = 1'b1;
      ifc.data_in = 9'd3;
      ifc.idle    = 1'b0;

      // Reset held five cycles with vaild asserted.
      wait_cycles(5);
      check("rst_ready",     32'(ifc.ready),     32'd0);
      check("rst_out_vaild", 32'(ifc.out_vaild), 32'd0);
      check("rst_fill",      32'(fill_level),    32'd0);
      check("rst_rx_cnt",    rx_cnt,             32'd0);
      check("rst_seq_err",   32'(seq_err),       32'd0);
      check("rst_af",        32'(almost_full),   32'd0);
      s_rst     = 1'b0;
      ifc.vaild = 1'b0;
      wait_cycles(1);
      check("rel_ready", 32'(ifc.ready),  32'd1);
      check("rel_fill",  32'(fill_level), 32'd0);

      // Back-to-back stream with the consumer always idle.
      clear_capture();
      ifc.idle = 1'b1;
      for (int i = 0; i < 20; i++) send(WIDTH'(i));
      wait_cycles(5);
      check("stream_count", 32'(out_q.size()), 32'd20);
      for (int i = 0; i < 20 && i < out_q.size(); i++)
         check("stream_data", 32'(out_q[i]), 32'(i));
      if (stamp_q.size() == 20)
         check("stream_one_per_cycle", 32'(stamp_q[19] - stamp_q[0]), 32'd19);
      check("stream_rx_cnt",   rx_cnt,                  32'd20);
      check("stream_seq_err",  32'(seq_err),            32'd0);
      check("stream_max_fill", 32'(max_fill <= 1),      32'd1);
      check("stream_fill_end", 32'(fill_level),         32'd0);

      // Fill to full with the consumer busy, then drain.
      clear_capture();
      ifc.idle = 1'b0;
      for (int i = 0; i < 5; i++) send(WIDTH'(20 + i));
      wait_cycles(1);
      check("fill5_level", 32'(fill_level),  32'd5);
      check("fill5_af",    32'(almost_full), 32'd0);
      send(9'd25);
      wait_cycles(1);
      check("fill6_level", 32'(fill_level),  32'd6);
      check("fill6_af",    32'(almost_full), 32'd1);
      send(9'd26);
      send(9'd27);
      wait_cycles(1);
      check("full_level",  32'(fill_level),  32'd8);
      check("full_ready",  32'(ifc.ready),   32'd0);
      check("full_rx_cnt", rx_cnt,           32'd28);
      ifc.vaild   = 1'b1;
      ifc.data_in = 9'd28;
      wait_cycles(3);
      check("full_hold_ready", 32'(ifc.ready),     32'd0);
      check("full_hold_level", 32'(fill_level),    32'd8);
      check("full_hold_rx",    rx_cnt,             32'd28);
      check("full_no_output",  32'(out_q.size()),  32'd0);
      ifc.idle = 1'b1;
      send(9'd28);
      send(9'd29);
      wait_cycles(15);
      check("drain_count", 32'(out_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < out_q.size(); i++)
         check("drain_data", 32'(out_q[i]), 32'(20 + i));
      check("drain_rx_cnt",   rx_cnt,            32'd30);
      check("drain_fill",     32'(fill_level),   32'd0);
      check("drain_af",       32'(almost_full),  32'd0);
      check("drain_max_fill", 32'(max_fill),     32'd8);
      check("drain_seq_err",  32'(seq_err),      32'd0);

      // Idle toggled with growing periods while a long stream runs.
      clear_capture();
      fork
         begin
            for (int i = 0; i < 500; i++) send(WIDTH'(30 + i));
         end
         begin
            for (int r = 0; r < 10; r++) begin
               ifc.idle = 1'b0;
               #(10 * (1 + (r * 14) / 9));
               ifc.idle = 1'b1;
               #(10 * (1 + (r * 14) / 9));
            end
         end
      join
      wait_cycles(20);
      check("toggle_count", 32'(out_q.size()), 32'd500);
      for (int i = 0; i < 500 && i < out_q.size(); i++) begin
         exp_w = WIDTH'(30 + i);
         check("toggle_data", 32'(out_q[i]), 32'(exp_w));
      end
      check("toggle_seq_err",  32'(seq_err),       32'd0);
      check("toggle_max_fill", 32'(max_fill <= 8), 32'd1);
      check("toggle_rx_cnt",   rx_cnt,             32'd530);

      // Sequence error: 5,6,7,9,10,11 after a fresh reset.
      ifc.idle = 1'b0;
      pulse_reset();
      clear_capture();
      check("seq_rst_err", 32'(seq_err), 32'd0);
      check("seq_rst_rx",  rx_cnt,       32'd0);
      send(9'd5);
      send(9'd6);
      send(9'd7);
      wait_cycles(1);
      check("seq_before_gap", 32'(seq_err), 32'd0);
      send(9'd9);
      wait_cycles(1);
      check("seq_after_gap", 32'(seq_err), 32'd1);
      send(9'd10);
      wait_cycles(1);
      check("seq_sticky_10", 32'(seq_err), 32'd1);
      send(9'd11);
      wait_cycles(1);
      check("seq_sticky_11", 32'(seq_err), 32'd1);
      check("seq_rx_cnt",    rx_cnt,       32'd6);
      ifc.idle = 1'b1;
      wait_cycles(10);
      check("seq_out_count", 32'(out_q.size()), 32'd6);
      for (int i = 0; i < 6 && i < out_q.size(); i++)
         check("seq_out_data", 32'(out_q[i]), 32'(seq5[i]));
      check("seq_still_set", 32'(seq_err), 32'd1);

      // Reset in the middle of operation discards stored words.
      clear_capture();
      ifc.idle = 1'b0;
      for (int i = 0; i < 5; i++) send(WIDTH'(100 + i));
      wait_cycles(1);
      check("mid_fill5", 32'(fill_level), 32'd5);
      pulse_reset();
      check("mid_rst_fill",      32'(fill_level),    32'd0);
      check("mid_rst_rx",        rx_cnt,             32'd0);
      check("mid_rst_seq_err",   32'(seq_err),       32'd0);
      check("mid_rst_out_vaild", 32'(ifc.out_vaild), 32'd0);
      check("mid_rst_af",        32'(almost_full),   32'd0);
      ifc.idle = 1'b1;
      send(9'd200);
      wait_cycles(5);
      check("mid_first_count", 32'(out_q.size()), 32'd1);
      if (out_q.size() > 0)
         check("mid_first_word", 32'(out_q[0]), 32'd200);

      // Pointer wrap-around: three full depths with the consumer idle.
      for (int i = 1; i <= 3 * DEPTH; i++) send(WIDTH'(200 + i));
      wait_cycles(10);
      check("wrap_count", 32'(out_q.size()), 32'd25);
      for (int i = 0; i < 25 && i < out_q.size(); i++)
         check("wrap_data", 32'(out_q[i]), 32'(200 + i));
      check("wrap_seq_err", 32'(seq_err),     32'd0);
      check("wrap_rx_cnt",  rx_cnt,           32'd25);
      check("wrap_fill",    32'(fill_level),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_destination_v2
`default_nettype wire
